majority_window_filter: RTL and testbench
=========================================

# majority_window_filter

Streaming successor to the combinational majority voter. Accepts one serial bit per valid cycle, keeps the last WINDOW samples in a shift register, and maintains a running population count incrementally rather than re-summing. The registered majority decision is produced once the window is full. It sits after noisy single-bit sources such as debounced inputs or line-code slicers, and emits a one-cycle-latency filtered bit stream.

## Interface
- WINDOW, 5, number of samples voted on; legal range 3..64.
- THRESHOLD, WINDOW/2+1, ones-count at or above which the vote is 1; legal range 1..WINDOW.
- HYST_LO, WINDOW/2-1, ones-count at or below which the vote clears; used only with hysteresis compiled in; must be < THRESHOLD.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bit is a sample this cycle.
- in_bit  in  1  serial input sample.
- flush  in  1  synchronous clear of window contents.
- out_valid  out  1  one-cycle pulse; out_num/out_count are a new vote.
- out_num  out  1  registered majority decision.
- out_count  out  $clog2(WINDOW+1)  ones-count of the window after the last accepted sample.
- full  out  1  window holds WINDOW samples.

## Operation
- State: shift register win[WINDOW-1:0] (win[0] newest), ones counter cnt, fill counter fill (0..WINDOW, saturating).
- Accepted sample (in_valid=1, flush=0): win shifts left, in_bit enters win[0].
- cnt_next = cnt + in_bit - (fill==WINDOW ? win[WINDOW-1] : 0). cnt never exceeds WINDOW and never underflows.
- fill increments until it reaches WINDOW, then holds. full = (fill==WINDOW).
- Vote (no hysteresis): out_num <= (cnt_next >= THRESHOLD). The vote updates only on accepted samples where fill_next==WINDOW.
- While fill_next < WINDOW: out_valid=0, out_num holds, out_count still tracks cnt_next.
- flush=1: win, cnt, fill, out_num and out_valid clear next cycle. flush together with in_valid: flush wins and the sample is dropped.
- in_valid=0: no state change; out_valid=0.
- Comparison width: THRESHOLD and HYST_LO are compared at out_count width. No truncation is allowed for WINDOW up to 64.

## Timing
- Reset values: out_valid=0, out_num=0, out_count=0, full=0, win=0, fill=0.
- Reset asserted mid-stream clears everything immediately (asynchronously). The first accepted sample after release starts a new fill.
- Latency: the sample accepted at edge N is reflected in out_num/out_count/out_valid right after edge N (registered, 1 cycle from the in_valid cycle).
- First out_valid comes on the WINDOW-th accepted sample after reset or flush. Afterwards out_valid follows every accepted sample.
- No backpressure: every in_valid cycle without flush is consumed.

## Configuration
- MAJ_WINDOW_HYST_EN defined: out_num sets when cnt_next >= THRESHOLD and clears when cnt_next <= HYST_LO; otherwise it holds its previous value.
- MAJ_WINDOW_HYST_EN undefined: pure threshold compare. HYST_LO is ignored, and out_num is recomputed on every vote.

## Test plan
- Reset then fill (WINDOW=5): bits 1,1,0,1,0 on consecutive valid cycles. out_valid stays 0 for the first 4 samples and pulses on the 5th, with out_count=3, out_num=1, full=1.
- Sliding window: continue with 0,0 from the previous state. Votes are count 2, out_num=0, then count 1, out_num=0. This checks oldest-bit subtraction.
- Gapped valid: in_valid toggles 1,0,1,0 with bits 1,x,1,x into an all-ones window. out_valid pulses only on valid cycles, and count stays 5.
- Flush collision: flush=1 and in_valid=1 with in_bit=1 in the same cycle. Next cycle cnt=0, fill=0, full=0, out_num=0; the sample is not counted.
- Async reset mid-stream: assert rst between edges after 3 samples. All outputs read 0 before the next edge; 5 fresh samples are needed for out_valid.
- Hysteresis (macro on, THRESHOLD=3, HYST_LO=1): drive counts 3 -> 2 -> 1 -> 2. out_num goes 1,1,0,0. With the macro off, the same stimulus gives 1,0,0,0.

Source files
------------

// File: rtl/majority_window_filter.sv
// majority_window_filter
//   Streaming majority vote over the last WINDOW accepted serial samples.
//   A running ones-count is updated incrementally: the newest bit is added and,
//   once the window is full, the bit shifted out is subtracted.
//   Optional feature: define MAJ_WINDOW_HYST_EN for a set/clear hysteresis vote
//   (set at cnt >= THRESHOLD, clear at cnt <= HYST_LO, otherwise hold).
module majority_window_filter #(
    parameter int WINDOW    = 5,
    parameter int THRESHOLD = WINDOW / 2 + 1,
    parameter int HYST_LO   = WINDOW / 2 - 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_bit,
    input  logic                           flush,
    output logic                           out_valid,
    output logic                           out_num,
    output logic [$clog2(WINDOW+1)-1:0]    out_count,
    output logic                           full
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
    localparam logic [CW-1:0] THR_C = CW'(THRESHOLD);
    localparam logic [CW-1:0] HYS_C = CW'(HYST_LO);

    // Elaboration-time guard on the legal parameter space
    if (WINDOW < 3 || WINDOW > 64 || THRESHOLD < 1 || THRESHOLD > WINDOW
        || HYST_LO >= THRESHOLD || HYST_LO < 0) begin : g_param_check
        $error("majority_window_filter: illegal parameter combination");
    end

    logic [WINDOW-1:0] win;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     fill;
    logic [CW-1:0]     cnt_next;
    logic [CW-1:0]     fill_next;
    logic              win_full;
    logic              dropped;
    logic              vote_next;

    assign win_full  = (fill == WIN_C);
    assign full      = win_full;
    assign out_count = cnt;

    // Next-state count/fill and the vote for the sample currently offered
    always_comb begin
        dropped   = win_full ? win[WINDOW-1] : 1'b0;
        cnt_next  = cnt + {{(CW-1){1'b0}}, in_bit} - {{(CW-1){1'b0}}, dropped};
        fill_next = win_full ? fill : fill + {{(CW-1){1'b0}}, 1'b1};
`ifdef MAJ_WINDOW_HYST_EN
        if (cnt_next >= THR_C)
            vote_next = 1'b1;
        else if (cnt_next <= HYS_C)
            vote_next = 1'b0;
        else
            vote_next = out_num;
`else
        vote_next = (cnt_next >= THR_C);
`endif
    end

    // Window, counters and registered vote; flush has priority over a sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= '0;
            cnt       <= '0;
            fill      <= '0;
            out_num   <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            win       <= '0;
            cnt       <= '0;
            fill      <= '0;
            out_num   <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            win       <= {win[WINDOW-2:0], in_bit};
            cnt       <= cnt_next;
            fill      <= fill_next;
            out_valid <= (fill_next == WIN_C);
            if (fill_next == WIN_C)
                out_num <= vote_next;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_majority_window_filter.sv
// Testbench for majority_window_filter (WINDOW=5, THRESHOLD=3, HYST_LO=1).
// Expected outputs come from a popcount-based window model and go through a
// scoreboard queue; fixed values from the directed scenarios are also checked.
module tb_majority_window_filter;

    localparam int W   = 5;
    localparam int THR = 3;
    localparam int HLO = 1;
    localparam int CW  = $clog2(W + 1);
    localparam int EW  = CW + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_bit;
    logic          flush;
    logic          out_valid;
    logic          out_num;
    logic [CW-1:0] out_count;
    logic          full;

    int vectors = 0;
    int miscompares = 0;

    // expected {out_valid, out_num, out_count, full}
    logic [EW-1:0] sb[$];

    // model state
    logic [W-1:0]  mw;
    int            mfill;
    logic          mnum;
    logic          mov;

    majority_window_filter #(.WINDOW(W), .THRESHOLD(THR), .HYST_LO(HLO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .flush(flush), .out_valid(out_valid), .out_num(out_num),
        .out_count(out_count), .full(full)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] observed();
        return {out_valid, out_num, out_count, full};
    endfunction

    task automatic model_reset();
        mw = '0; mfill = 0; mnum = 1'b0; mov = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, push the model's prediction, wait for the edge.
    task automatic drive(input logic v, input logic b, input logic f);
        int pc;
        @(negedge clk);
        in_valid = v; in_bit = b; flush = f;
        if (f) begin
            mw = '0; mfill = 0; mnum = 1'b0; mov = 1'b0;
        end else if (v) begin
            mw = {mw[W-2:0], b};
            if (mfill < W) mfill++;
            mov = (mfill == W);
            if (mov) begin
                pc = $countones(mw);
`ifdef MAJ_WINDOW_HYST_EN
                if (pc >= THR) mnum = 1'b1;
                else if (pc <= HLO) mnum = 1'b0;
`else
                mnum = (pc >= THR);
`endif
            end
        end else begin
            mov = 1'b0;
        end
        sb.push_back({mov, mnum, CW'($countones(mw)), (mfill == W)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_bit = 0; flush = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (observed() !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", observed(), {EW{1'b0}});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [4:0] bits = 5'b01011; // LSB first: 1,1,0,1,0
        logic [EW-1:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bits[i], 1'b0);
            e = sb.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL fill[%0d]: got %b expected %b", i, observed(), e);
            end
        end
        vectors++;
        if ({out_valid, out_num, out_count, full} !== {1'b1, 1'b1, CW'(3), 1'b1}) begin
            miscompares++;
            $display("FAIL fill_final: got %b expected v=1 num=1 cnt=3 full=1", observed());
        end
    endtask

    task automatic test_sliding();
        logic [EW-1:0] e;
        logic [CW-1:0] want_cnt [2];
        want_cnt[0] = CW'(2); want_cnt[1] = CW'(1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL slide[%0d]: got %b expected %b", i, observed(), e);
            end
            vectors++;
            if (out_count !== want_cnt[i] || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL slide_cnt[%0d]: got cnt=%0d v=%b expected cnt=%0d v=1",
                         i, out_count, out_valid, want_cnt[i]);
            end
        end
    endtask

    task automatic test_gapped();
        logic [EW-1:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            drive((i % 2) == 0, (i % 2) == 0 ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
            e = sb.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL gapped[%0d]: got %b expected %b", i, observed(), e);
            end
            vectors++;
            if (out_count !== CW'(5) || out_valid !== ((i % 2) == 0)) begin
                miscompares++;
                $display("FAIL gapped_cnt[%0d]: got cnt=%0d v=%b expected cnt=5 v=%b",
                         i, out_count, out_valid, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_flush();
        logic [EW-1:0] e;
        drive(1'b1, 1'b1, 1'b1);
        e = sb.pop_front();
        vectors++;
        if (observed() !== e || observed() !== '0) begin
            miscompares++;
            $display("FAIL flush_collision: got %b expected %b", observed(), e);
        end
        // refill: first out_valid only on the 5th accepted sample
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            e = sb.pop_front();
            vectors++;
            if (observed() !== e || out_valid !== (i == 4)) begin
                miscompares++;
                $display("FAIL flush_refill[%0d]: got %b expected %b", i, observed(), e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] e;
        drive(1'b1, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            void'(sb.pop_front());
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (observed() !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected %b", observed(), {EW{1'b0}});
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            e = sb.pop_front();
            vectors++;
            if (observed() !== e || out_valid !== (i == 4)) begin
                miscompares++;
                $display("FAIL post_reset_fill[%0d]: got %b expected %b", i, observed(), e);
            end
        end
    endtask

    task automatic test_hysteresis();
        logic [7:0] bits = 8'b10010011; // LSB first: 1,1,0,0,1,0,0,1
        logic [EW-1:0] e;
        logic [3:0] want_num;
`ifdef MAJ_WINDOW_HYST_EN
        want_num = 4'b0011; // LSB first: 1,1,0,0
`else
        want_num = 4'b0001; // LSB first: 1,0,0,0
`endif
        drive(1'b1, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits[i], 1'b0);
            e = sb.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL hyst[%0d]: got %b expected %b", i, observed(), e);
            end
            if (i >= 4) begin
                vectors++;
                if (out_num !== want_num[i-4]) begin
                    miscompares++;
                    $display("FAIL hyst_num[%0d]: got %b expected %b", i - 4, out_num, want_num[i-4]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_sliding();
        test_gapped();
        test_flush();
        test_async_reset();
        test_hysteresis();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
